// File: rtl/ccff_loader.sv
// Configuration-chain loader: serializes a byte stream onto ccff_head with a
// divided prog_clk, and optionally compares ccff_tail against the re-shifted stream.
module ccff_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int CLK_DIV   = 2,
  parameter int IDX_W     = $clog2(CHAIN_LEN) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             verify,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             ccff_tail,
  output logic             prog_clk,
  output logic             ccff_head,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [IDX_W-1:0] mismatch_idx
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             verify_q, verify_d;
  logic             pclk_q, pclk_d;
  logic             head_q, head_d;
  logic             mm_q, mm_d;
  logic [IDX_W-1:0] mmi_q, mmi_d;

  logic             phase_end;
  logic [IDX_W-1:0] cnt_inc;

  assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    verify_d = verify_q;
    mm_d     = mm_q;
    mmi_d    = mmi_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_FETCH;
          verify_d = verify;
          mm_d     = 1'b0;
          mmi_d    = '0;
          cnt_d    = '0;
        end
      end
      S_FETCH: begin
        if (byte_valid) begin
          byte_d  = byte_in;
          bit_d   = '0;
          div_d   = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = S_HIGH;
          // head_q already holds the bit being shifted; only the first miss is kept
          if (verify_q && (ccff_tail != head_q) && !mm_q) begin
            mm_d  = 1'b1;
            mmi_d = cnt_q;
          end
        end else begin
          div_d = DIV_W'(div_q + 1'b1);
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          div_d = '0;
          cnt_d = cnt_inc;
          if (cnt_inc == IDX_W'(CHAIN_LEN)) begin
            state_d = S_DONE;
          end else if (bit_q == 3'd7) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_LOW;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          div_d = DIV_W'(div_q + 1'b1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // prog_clk and ccff_head are registered from the next state so they never glitch
    pclk_d = (state_d == S_HIGH);
    unique case (state_d)
      S_LOW:   head_d = byte_d[bit_d];
      S_HIGH:  head_d = head_q;
      default: head_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      verify_q <= 1'b0;
      pclk_q   <= 1'b0;
      head_q   <= 1'b0;
      mm_q     <= 1'b0;
      mmi_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      verify_q <= verify_d;
      pclk_q   <= pclk_d;
      head_q   <= head_d;
      mm_q     <= mm_d;
      mmi_q    <= mmi_d;
    end
  end

  assign byte_ready   = (state_q == S_FETCH);
  assign busy         = (state_q == S_FETCH) || (state_q == S_LOW) || (state_q == S_HIGH);
  assign done         = (state_q == S_DONE);
  assign prog_clk     = pclk_q;
  assign ccff_head    = head_q;
  assign mismatch     = mm_q;
  assign mismatch_idx = mmi_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: two instances (12-bit/div 2 and 8-bit/div 1),
// each feeding a modelled shift-register chain.
module tb_ccff_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // instance A: CHAIN_LEN=12, CLK_DIV=2
  logic       start_a = 1'b0, verify_a = 1'b0, bv_a = 1'b0;
  logic [7:0] byte_a = '0;
  logic       br_a, tail_a, pclk_a, head_a, busy_a, done_a, mm_a;
  logic [4:0] mmi_a;
  // instance B: CHAIN_LEN=8, CLK_DIV=1
  logic       start_b = 1'b0, verify_b = 1'b0, bv_b = 1'b0;
  logic [7:0] byte_b = '0;
  logic       br_b, tail_b, pclk_b, head_b, busy_b, done_b, mm_b;
  logic [3:0] mmi_b;

  ccff_loader #(.CHAIN_LEN(12), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .verify(verify_a),
    .byte_in(byte_a), .byte_valid(bv_a), .byte_ready(br_a), .ccff_tail(tail_a),
    .prog_clk(pclk_a), .ccff_head(head_a), .busy(busy_a), .done(done_a),
    .mismatch(mm_a), .mismatch_idx(mmi_a)
  );

  ccff_loader #(.CHAIN_LEN(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .verify(verify_b),
    .byte_in(byte_b), .byte_valid(bv_b), .byte_ready(br_b), .ccff_tail(tail_b),
    .prog_clk(pclk_b), .ccff_head(head_b), .busy(busy_b), .done(done_b),
    .mismatch(mm_b), .mismatch_idx(mmi_b)
  );

  // fpga_top chain models
  logic [11:0] chain_a = '0;
  logic [7:0]  chain_b = '0;
  int rise_a = 0, rise_b = 0;
  assign tail_a = chain_a[11];
  assign tail_b = chain_b[7];
  always @(posedge pclk_a) begin
    chain_a <= {chain_a[10:0], head_a};
    rise_a  <= rise_a + 1;
  end
  always @(posedge pclk_b) begin
    chain_b <= {chain_b[6:0], head_b};
  end

  // negedge monitors: cycle count, high-phase length on A, rise spacing on B
  int   cyc = 0, hi_run_a = 0, bad_hi_a = 0;
  int   hs_a = 0, hs_b = 0, last_rise_b = 0, bad_rise_b = 0;
  logic prev_pb = 1'b0, have_rise_b = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (pclk_a) hi_run_a <= hi_run_a + 1;
    else begin
      if (hi_run_a != 0 && hi_run_a != 2 && !reset) bad_hi_a <= bad_hi_a + 1;
      hi_run_a <= 0;
    end
    prev_pb <= pclk_b;
    if (pclk_b && !prev_pb) begin
      rise_b <= rise_b + 1;
      if (have_rise_b && (cyc - last_rise_b != 2)) bad_rise_b <= bad_rise_b + 1;
      last_rise_b <= cyc;
      have_rise_b <= 1'b1;
    end
  end
  always @(posedge clk) begin
    if (bv_a && br_a) hs_a <= hs_a + 1;
    if (bv_b && br_b) hs_b <= hs_b + 1;
  end

  int n_chk = 0, n_fail = 0, tmo = 0;
  int t0 = 0, t1 = 0, r0 = 0, h0 = 0, zeros = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_a_pass(input logic vmode);
    @(negedge clk);
    start_a  = 1'b1;
    verify_a = vmode;
    @(negedge clk);
    start_a  = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_a(input logic [7:0] b);
    int n = 0;
    byte_a = b;
    bv_a   = 1'b1;
    while (!br_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) tmo++;
    @(negedge clk);
    bv_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) tmo++;
    t1 = cyc;
  endtask

  task automatic pass_a(input logic vmode, input logic [7:0] b0, input logic [7:0] b1);
    start_a_pass(vmode);
    send_a(b0);
    send_a(b1);
    wait_done_a();
  endtask

  initial begin
    // reset state
    #1;
    chk("reset_outs_a", {21'd0, br_a, pclk_a, head_a, busy_a, done_a, mm_a, mmi_a}, 32'd0);
    chk("reset_outs_b", {22'd0, br_b, pclk_b, head_b, busy_b, done_b, mm_b, mmi_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // basic load: 0xA5, 0x03 -> heads 1,0,1,0,0,1,0,1,1,1,0,0
    r0 = rise_a; h0 = hs_a;
    pass_a(1'b0, 8'hA5, 8'h03);
    chk("basic_rises", rise_a - r0, 12);
    chk("basic_chain", chain_a, 12'hA5C);
    chk("basic_bytes", hs_a - h0, 2);
    chk("basic_done_busy", {done_a, busy_a}, 2'b10);
    chk("basic_cycles", t1 - t0, 50);
    chk("basic_high_len", bad_hi_a, 0);

    // verify passes against the modelled chain
    pass_a(1'b1, 8'hA5, 8'h03);
    chk("vfy_same_mm", mm_a, 1'b0);
    chk("vfy_same_done", done_a, 1'b1);
    pass_a(1'b1, 8'hA4, 8'h03);
    chk("vfy_bit0_mm", mm_a, 1'b1);
    chk("vfy_bit0_idx", mmi_a, 5'd0);
    pass_a(1'b1, 8'hA4, 8'h07);
    chk("vfy_bit10_mm", mm_a, 1'b1);
    chk("vfy_bit10_idx", mmi_a, 5'd10);
    pass_a(1'b1, 8'hA5, 8'h03);
    chk("vfy_first_idx", mmi_a, 5'd0);
    chk("vfy_chain", chain_a, 12'hA5C);

    // start in DONE clears status; byte_ready follows next cycle
    start_a_pass(1'b0);
    chk("restart_clear", {done_a, mm_a, mmi_a}, 7'd0);
    chk("restart_ready", br_a, 1'b1);
    send_a(8'hA5);
    send_a(8'h03);
    wait_done_a();
    chk("restart_chain", chain_a, 12'hA5C);

    // stall 10 cycles between bytes
    r0 = rise_a;
    start_a_pass(1'b0);
    send_a(8'hA5);
    begin
      int n = 0;
      while (!br_a && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) tmo++;
    end
    h0 = rise_a;
    zeros = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!pclk_a) zeros++;
    end
    chk("stall_pclk_low", zeros, 10);
    chk("stall_no_rise", rise_a - h0, 0);
    send_a(8'h03);
    wait_done_a();
    chk("stall_rises", rise_a - r0, 12);
    chk("stall_chain", chain_a, 12'hA5C);

    // start pulsed during HIGH is ignored
    r0 = rise_a;
    start_a_pass(1'b0);
    send_a(8'hA5);
    begin
      int n = 0;
      while (!pclk_a && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) tmo++;
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    send_a(8'h03);
    wait_done_a();
    chk("hi_start_rises", rise_a - r0, 12);
    chk("hi_start_cycles", t1 - t0, 50);
    chk("hi_start_chain", chain_a, 12'hA5C);

    // reset after the 5th rise, then a full reload
    r0 = rise_a;
    start_a_pass(1'b0);
    send_a(8'h5A);
    begin
      int n = 0;
      while (!((rise_a - r0 == 5) && pclk_a) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) tmo++;
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst_outs", {21'd0, br_a, pclk_a, head_a, busy_a, done_a, mm_a, mmi_a}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    pass_a(1'b0, 8'hA5, 8'h03);
    chk("midrst_reload", chain_a, 12'hA5C);
    chk("midrst_high_len", bad_hi_a, 0);

    // byte-aligned 8-bit chain, CLK_DIV=1; byte_valid kept high afterwards
    h0 = hs_b;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    byte_b  = 8'h81;
    bv_b    = 1'b1;
    begin
      int n = 0;
      while (!br_b && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) tmo++;
      @(negedge clk);
      byte_b = 8'hFF;
      n = 0;
      while (!done_b && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) tmo++;
    end
    repeat (4) @(negedge clk);
    bv_b = 1'b0;
    chk("b_rises", rise_b, 8);
    chk("b_rise_spacing", bad_rise_b, 0);
    chk("b_bytes", hs_b - h0, 1);
    chk("b_chain", chain_b, 8'h81);
    chk("b_done_busy", {done_b, busy_b}, 2'b10);

    chk("timeouts", tmo, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader that sits directly upstream of `fpga_top`. It takes the bitstream as a byte stream over a valid/ready handshake and serializes it onto `ccff_head`. It generates `prog_clk` from the system clock. In verify mode it re-shifts a bitstream and compares `ccff_tail` against it, flagging the first mismatching bit.

## Interface
- `CHAIN_LEN`, default 64: number of configuration flip-flops in the chain (≥1).
- `CLK_DIV`, default 2: `prog_clk` half-period in `clk` cycles (≥1).
- `IDX_W`, default `$clog2(CHAIN_LEN)+1`: width of bit counters and `mismatch_idx`.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load or verify pass.
- `verify` in 1: mode select, sampled on an accepted `start`.
- `byte_in` in 8: bitstream byte.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `ccff_tail` in 1: chain output, from `fpga_top`.
- `prog_clk` out 1: chain shift clock, registered, to `fpga_top`.
- `ccff_head` out 1: chain serial input, registered.
- `busy` out 1: pass in progress.
- `done` out 1: last pass completed; held until the next accepted `start`.
- `mismatch` out 1: verify pass saw at least one differing bit.
- `mismatch_idx` out `IDX_W`: index of the first mismatching bit (0 = first bit shifted).

## Operation
- States are IDLE, FETCH, LOW, HIGH and DONE.
- **Reset values:** all outputs are 0. State is IDLE. Counters are 0.
- **Start:**
  - `start` in IDLE or DONE goes to FETCH.
  - On that edge the block latches `verify` and clears `done`, `mismatch` and `mismatch_idx`. Bit counter is set to 0.
  - `start` in FETCH, LOW or HIGH is ignored.
- **FETCH:**
  - `byte_ready`=1, `prog_clk`=0, `ccff_head`=0.
  - When `byte_valid` && `byte_ready`, the block latches `byte_in` and moves to LOW with bit-in-byte index 0.
  - If `byte_valid`=0 the block stalls indefinitely in FETCH.
- **LOW:**
  - Lasts `CLK_DIV` cycles with `prog_clk`=0 and `ccff_head` = latched byte bit [bit-in-byte].
  - Bits are sent LSB first; bytes are sent in arrival order.
  - On the last LOW cycle in verify mode, the block compares `ccff_tail` with the current bit.
  - If they differ and `mismatch`=0, it sets `mismatch`=1 and `mismatch_idx` = bit counter. Later mismatches do not update `mismatch_idx`.
- **HIGH:**
  - Lasts `CLK_DIV` cycles with `prog_clk`=1; `ccff_head` is unchanged.
  - On the last HIGH cycle the bit counter increments. The next state is:
    - DONE if the counter reaches `CHAIN_LEN`;
    - else FETCH if bit-in-byte == 7;
    - else LOW with bit-in-byte+1.
- **DONE:** `done`=1, `busy`=0, `prog_clk`=0, `ccff_head`=0.
- **`busy`:** 1 in FETCH, LOW and HIGH.
- **Partial last byte:**
  - The block consumes exactly ceil(`CHAIN_LEN`/8) bytes.
  - In the final byte only bits [(`CHAIN_LEN`-1)%8:0] are shifted; the upper bits are discarded.
- **Verify semantics:** the chain tail holds the first bit of the previous pass. Re-shifting the same bitstream therefore yields tail bit k = previous bit k. Verify mode still shifts, so the chain ends up holding the verify stream.
- **Reset mid-pass:**
  - All outputs drop to 0 immediately (asynchronously) and the state returns to IDLE.
  - The chain contents are undefined; the host must redo a full load.

## Timing
- `byte_ready` rises the cycle after an accepted `start`.
- After a byte handshake, LOW begins on the next cycle.
- `ccff_head` changes only on entry to LOW or FETCH/DONE, i.e. coincident with `prog_clk` low. It is stable for `CLK_DIV` cycles before each `prog_clk` rise and for `CLK_DIV` cycles after it.
- Each bit takes 2·`CLK_DIV` cycles, plus one FETCH cycle per byte when `byte_valid` is already high.
- `done` rises the cycle after the last HIGH cycle.
- `mismatch` updates the cycle after the sampling LOW cycle.
- `ccff_tail` is sampled on the `clk` edge ending the last LOW cycle.

## Test plan
- **Basic load:** `CHAIN_LEN`=12, `CLK_DIV`=2; start (load); send 0xA5 then 0x03.
  - `ccff_head` at the 12 `prog_clk` rises is 1,0,1,0,0,1,0,1,1,1,0,0.
  - Each high phase is 2 cycles; exactly 2 bytes are accepted; then `done`=1, `busy`=0.
- **Verify** (bench models a 12-bit shift register chain):
  - Load 0xA5,0x03, then verify with 0xA5,0x03 → `mismatch`=0.
  - Re-verify with 0xA4,0x03 → `mismatch`=1, `mismatch_idx`=0.
- **Stall:** hold `byte_valid`=0 for 10 cycles between bytes.
  - `prog_clk` stays 0 with no extra rises.
  - The received chain contents are identical to the basic load.
- **Reset mid-load:** assert `reset` after the 5th `prog_clk` rise.
  - All outputs are 0 in the same cycle.
  - A subsequent full load produces correct chain contents.
- **Start handling:**
  - `start` pulsed during HIGH is ignored (bit count and timing unchanged).
  - `start` in DONE clears `done` and `mismatch`, and `byte_ready` rises the next cycle.
- **Byte-aligned chain:** `CLK_DIV`=1, `CHAIN_LEN`=8; send 0x81.
  - `prog_clk` rises every 2 cycles, 8 rises total.
  - `done` follows after 1 byte; a second valid byte is not accepted.
